alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Sequencer that runs an N-bit arithmetic operation through one external 1-bit arithmetic slice, one bit per clock, LSB first. The slice has a mux-selected B operand (0, B, ~B, 1) feeding a full adder. This block accepts a word-level request, serialises operands into the slice, carries the ripple carry in a flop between cycles, and assembles the result word. It sits between the ALU front-end request path and the 1-bit slice instance in the ALU top.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  block can accept a request.
- op_i  in  3  operation; op_i[2:1] drives slice select, op_i[0] is initial carry-in.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  WIDTH  result word.
- cout_o  out  1  carry out of MSB.
- slice_a_o  out  1  A bit to slice.
- slice_b_o  out  1  B bit to slice.
- slice_sel_o  out  2  B-mux select to slice.
- slice_cin_o  out  1  carry-in to slice.
- slice_d_i  in  1  slice sum bit (combinational from slice_*_o).
- slice_cout_i  in  1  slice carry-out.

## Operation
- Op encoding (A + Bsel + cin): 000 A; 001 A+1; 010 A+B; 011 A+B+1; 100 A+~B; 101 A−B; 110 A−1; 111 A.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, latch a_i, b_i, op_i into shift/op registers, clear bit counter to 0, load carry flop with op_i[0], go SHIFT.
- SHIFT: in_ready_o=0. slice_a_o=A_reg[0], slice_b_o=B_reg[0], slice_sel_o=op_reg[2:1], slice_cin_o=carry flop. Each cycle: shift slice_d_i into result register from MSB side, shift A_reg/B_reg right by one, carry flop <= slice_cout_i, counter++. On the cycle with counter==WIDTH−1, go DONE and register slice_cout_i into cout_o.
- DONE: out_valid_o=1, result_o and cout_o held stable. On out_ready_i, go IDLE, drop out_valid_o.
- Outside SHIFT, slice_a_o, slice_b_o, slice_sel_o, and slice_cin_o are driven to 0.
- in_valid_i while not in IDLE is ignored; the request stays pending upstream under valid/ready rules.
- Counter width is $clog2(WIDTH). There is no wrap past WIDTH−1.
- Reset: in_ready_o=0 during reset, then 1 in IDLE. out_valid_o=0, result_o=0, cout_o=0, and all slice_* outputs=0. Reset asserted mid-SHIFT or in DONE abandons the operation, and no out_valid_o is produced for it.

## Timing
- Request accepted on edge T. SHIFT occupies cycles T+1..T+WIDTH. out_valid_o rises after edge T+WIDTH, so latency is WIDTH+1 cycles.
- With out_ready_i held high, the result handshake completes on the first DONE edge. The next request is accepted one cycle later. Minimum initiation interval is WIDTH+2 cycles.
- A result is held indefinitely under backpressure.
- The slice path is combinational within one cycle: slice_*_o to slice_d_i/slice_cout_i to the registers.

## Configuration
- ALU_SERIAL_FLAGS_EN defined: adds outputs zero_o (1 when result_o==0) and ovf_o (signed overflow = carry into MSB XOR carry out of MSB). Both are registered on entry to DONE, valid with out_valid_o, and 0 in reset.
- The carry into the MSB is captured from the carry flop on the last SHIFT cycle.
- ALU_SERIAL_FLAGS_EN undefined: zero_o and ovf_o ports, and their logic, are absent.

## Test plan
Bench uses WIDTH=8 and instantiates the real 1-bit slice.
- Add: op=010, A=0x7F, B=0x01 -> out_valid_o rises 9 cycles after accept; result 0x80, cout 0, ovf 1 (flags build).
- Subtract: op=101, A=0x05, B=0x07 -> result 0xFE, cout 0, zero 0. With A=0x07, B=0x05 -> 0x02, cout 1.
- Increment/decrement: op=001, A=0xFF -> result 0x00, cout 1, zero 1. op=110, A=0x00 -> result 0xFF, cout 0.
- Backpressure: hold out_ready_i=0 for 5 cycles after valid -> result_o/cout_o stable, in_ready_o=0, second in_valid_i ignored. Release -> IDLE next cycle, then the second request is accepted.
- Reset mid-op: assert rst_ni=0 at SHIFT bit 3 -> next edge all outputs 0, in_ready_o=1 after release, no stray out_valid_o. A new op=010 with 0x12+0x34 -> 0x46.
- Back-to-back: 4 random ops with out_ready_i=1 -> each result matches the reference model, and accepts are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: runs a WIDTH-bit add/sub through an external 1-bit slice, LSB first
// Ports: clk_i/rst_ni (sync, active-low); in_valid_i/in_ready_o, op_i, a_i, b_i request;
// out_valid_o/out_ready_i, result_o, cout_o result; slice_a_o/slice_b_o/slice_sel_o/slice_cin_o
// drive the slice, slice_d_i/slice_cout_i return from it.
// Optional: ALU_SERIAL_FLAGS_EN adds registered zero_o and ovf_o flags.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic [1:0]       slice_sel_o,
  output logic             slice_cin_o,
  input  logic             slice_d_i,
  input  logic             slice_cout_i
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             zero_o,
  output logic             ovf_o
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, res_next;
  logic [1:0]       sel_q;
  logic             carry_q, shift, last;
  logic [CW-1:0]    cnt;
  always_comb begin
    shift       = state == SHIFT;
    last        = cnt == CW'(WIDTH - 1);
    res_next    = {slice_d_i, result_o[WIDTH-1:1]};
    slice_a_o   = shift & a_q[0];
    slice_b_o   = shift & b_q[0];
    slice_sel_o = shift ? sel_q : 2'b00;
    slice_cin_o = shift & carry_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      cout_o      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 2'b00;
      carry_q     <= 1'b0;
      cnt         <= '0;
`ifdef ALU_SERIAL_FLAGS_EN
      zero_o      <= 1'b0;
      ovf_o       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready_o <= 1'b1;
          if (in_valid_i && in_ready_o) begin
            a_q        <= a_i;
            b_q        <= b_i;
            sel_q      <= op_i[2:1];
            carry_q    <= op_i[0];
            cnt        <= '0;
            in_ready_o <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          result_o <= res_next;
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          carry_q  <= slice_cout_i;
          cnt      <= last ? cnt : cnt + 1'b1;
          if (last) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
            cout_o      <= slice_cout_i;
`ifdef ALU_SERIAL_FLAGS_EN
            zero_o      <= res_next == '0;
            // carry_q still holds the carry into the MSB on this last bit
            ovf_o       <= carry_q ^ slice_cout_i;
`endif
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed and model-checked bench for alu_serial_ctrl at WIDTH=8
module tb_alu_serial_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic in_valid_i = 1'b0, in_ready_o, out_valid_o, out_ready_i = 1'b1, cout_o;
  logic [2:0] op_i = 3'b000;
  logic [W-1:0] a_i = '0, b_i = '0, result_o;
  logic slice_a_o, slice_b_o, slice_cin_o, slice_d_i, slice_cout_i, bs;
  logic [1:0] slice_sel_o;
`ifdef ALU_SERIAL_FLAGS_EN
  logic zero_o, ovf_o;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .cout_o(cout_o), .slice_a_o(slice_a_o), .slice_b_o(slice_b_o),
    .slice_sel_o(slice_sel_o), .slice_cin_o(slice_cin_o), .slice_d_i(slice_d_i),
    .slice_cout_i(slice_cout_i)
`ifdef ALU_SERIAL_FLAGS_EN
    , .zero_o(zero_o), .ovf_o(ovf_o)
`endif
  );
  always_comb begin
    bs = slice_sel_o == 2'd0 ? 1'b0 : slice_sel_o == 2'd1 ? slice_b_o :
         slice_sel_o == 2'd2 ? ~slice_b_o : 1'b1;
    slice_d_i    = slice_a_o ^ bs ^ slice_cin_o;
    slice_cout_i = (slice_a_o & bs) | (slice_cin_o & (slice_a_o ^ bs));
  end
  typedef struct {logic [W-1:0] r; logic c; logic z; logic v;} exp_t;
  exp_t q[$];
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] bm;
    logic [W:0] s;
    exp_t e;
    bm  = op[2:1] == 2'd0 ? '0 : op[2:1] == 2'd1 ? b : op[2:1] == 2'd2 ? ~b : '1;
    s   = {1'b0, a} + {1'b0, bm} + (W+1)'(op[0]);
    e.r = s[W-1:0];
    e.c = s[W];
    e.z = e.r == '0;
    e.v = (a[W-1] == bm[W-1]) && (e.r[W-1] != a[W-1]);
    return e;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (!rst_ni) q.delete();
    else begin
      if (in_valid_i && in_ready_o) q.push_back(model(op_i, a_i, b_i));
      if (out_valid_o && out_ready_i && q.size() > 0) void'(q.pop_front());
    end
  end
  always @(negedge clk) begin
    if (rst_ni && out_valid_o) begin
      chk("ready_while_valid", in_ready_o, 1'b0);
      if (q.size() == 0) chk("stray_valid", 1'b1, 1'b0);
      else begin
        chk("model_result", result_o, q[0].r);
        chk("model_cout", cout_o, q[0].c);
`ifdef ALU_SERIAL_FLAGS_EN
        chk("model_zero", zero_o, q[0].z);
        chk("model_ovf", ovf_o, q[0].v);
`endif
      end
    end
  end
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, b, output int n);
    op_i = op; a_i = a; b_i = b; in_valid_i = 1'b1; n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!in_ready_o && n < 40);
    #1 in_valid_i = 1'b0;
    if (n >= 40) chk("accept_timeout", 1'b0, 1'b1);
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid_o && lat < 40) begin
      @(posedge clk) #1;
      lat++;
    end
    if (!out_valid_o) chk("valid_timeout", 1'b0, 1'b1);
  endtask
  task automatic check_idle_zero(input string nm);
    chk({nm, "_valid"}, out_valid_o, 1'b0);
    chk({nm, "_result"}, result_o, '0);
    chk({nm, "_cout"}, cout_o, 1'b0);
    chk({nm, "_slice"}, {slice_a_o, slice_b_o, slice_sel_o, slice_cin_o}, 5'b0);
`ifdef ALU_SERIAL_FLAGS_EN
    chk({nm, "_flags"}, {zero_o, ovf_o}, 2'b00);
`endif
  endtask
  task automatic op_lit(input string nm, input logic [2:0] op, input logic [W-1:0] a, b,
                        input logic [W-1:0] r, input logic c, input logic z, input logic v);
    int n, lat;
    send(op, a, b, n);
    wait_valid(lat);
    chk({nm, "_latency"}, lat, W + 1);
    chk({nm, "_res"}, result_o, r);
    chk({nm, "_cout"}, cout_o, c);
`ifdef ALU_SERIAL_FLAGS_EN
    chk({nm, "_zero"}, zero_o, z);
    chk({nm, "_ovf"}, ovf_o, v);
`else
    if (z === 1'bx || v === 1'bx) chk({nm, "_flagarg"}, 1'b0, 1'b1);
`endif
    @(posedge clk) #1;
    chk({nm, "_drop"}, out_valid_o, 1'b0);
  endtask
  initial begin
    int n, lat;
    logic [W-1:0] r0;
    logic c0;
    #200000 $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    int n, lat;
    logic [W-1:0] r0;
    logic c0;
    repeat (3) @(posedge clk);
    #1 chk("rst_ready", in_ready_o, 1'b0);
    check_idle_zero("rst");
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("ready_after_rst", in_ready_o, 1'b1);
    op_lit("add", 3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    op_lit("sub_neg", 3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
    op_lit("sub_pos", 3'b101, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0);
    op_lit("inc", 3'b001, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    op_lit("dec", 3'b110, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    op_lit("pass", 3'b000, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0);
    out_ready_i = 1'b0;
    send(3'b011, 8'h40, 8'h3F, n);
    wait_valid(lat);
    chk("bp_res", result_o, 8'h80);
    r0 = result_o; c0 = cout_o;
    op_i = 3'b010; a_i = 8'h10; b_i = 8'h20; in_valid_i = 1'b1;
    repeat (5) begin
      @(posedge clk) #1;
      chk("bp_hold_res", result_o, r0);
      chk("bp_hold_cout", cout_o, c0);
      chk("bp_ready", in_ready_o, 1'b0);
      chk("bp_valid", out_valid_o, 1'b1);
    end
    out_ready_i = 1'b1;
    @(posedge clk) #1;
    chk("bp_release_valid", out_valid_o, 1'b0);
    chk("bp_release_ready", in_ready_o, 1'b1);
    send(3'b010, 8'h10, 8'h20, n);
    chk("bp_second_accept", n, 1);
    wait_valid(lat);
    chk("bp_second_res", result_o, 8'h30);
    @(posedge clk) #1;
    send(3'b010, 8'hAA, 8'h11, n);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b0;
    @(posedge clk) #1;
    chk("mid_rst_ready", in_ready_o, 1'b0);
    check_idle_zero("mid_rst");
    rst_ni = 1'b1;
    n = 0;
    while (!in_ready_o && n < 5) begin
      @(posedge clk) #1;
      n++;
      chk("mid_rst_no_valid", out_valid_o, 1'b0);
    end
    chk("mid_rst_ready_back", in_ready_o, 1'b1);
    op_lit("post_rst_add", 3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
    send(3'($urandom), 8'($urandom), 8'($urandom), n);
    for (int i = 0; i < 3; i++) begin
      send(3'($urandom), 8'($urandom), 8'($urandom), n);
      chk("b2b_spacing", n, W + 2);
    end
    wait_valid(lat);
    repeat (3) @(posedge clk);
    #1 chk("end_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
